// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding unit.
// Provides the scoreboard entry struct, forwarding select codes and a match helper.
package pipe_pkg;

    localparam int REG_W_DEF = 5;
    // Entries are stored at a fixed maximum width; narrower register
    // numbers are zero-extended on the way in.
    localparam int REG_W_MAX = 8;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic                 wreg;
        logic                 m2reg;
        logic [REG_W_MAX-1:0] wn;
    } sb_entry_t;

    function automatic logic sb_hit(sb_entry_t e, logic [REG_W_MAX-1:0] s);
        return e.valid && e.wreg && (e.wn == s);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select: compares one source register against the
// EX/MEM/WB scoreboard entries and returns {sel, load_use, stall_req}.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic                 id_valid,
    input  logic [REG_W_MAX-1:0] src,
    input  logic                 use_src,
    input  sb_entry_t            ex,
    input  sb_entry_t            mem,
    input  sb_entry_t            wb,
    output logic [1:0]           sel,
    output logic                 load_use,
    output logic                 stall_req
);

    logic live;
    logic m_ex;
    logic m_mem;
    logic m_wb;
    logic unused_m2reg;

    assign unused_m2reg = ^{mem.m2reg, wb.m2reg};

    always_comb begin
        sel       = FWD_RF;
        load_use  = 1'b0;
        stall_req = 1'b0;
        live  = id_valid && use_src && (src != '0);
        m_ex  = live && sb_hit(ex, src);
        m_mem = live && sb_hit(mem, src);
        m_wb  = live && sb_hit(wb, src);
        if (FWD_EN) begin
            // Youngest producer wins; a load still in EX has no data yet.
            if (m_ex) begin
                if (ex.m2reg) load_use = 1'b1;
                else          sel      = FWD_EX;
            end else if (m_mem) begin
                sel = FWD_MEM;
            end else if (m_wb && !RF_BYPASS) begin
                sel = FWD_WB;
            end
        end else begin
            stall_req = m_ex || m_mem || (m_wb && !RF_BYPASS);
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller beside ID: tracks EX/MEM/WB destinations,
// drives EX operand selects, load-use/interlock stalls, branch flushes, freeze.
// In : clk, clrn, id_* (issuing instruction), ex_branch_taken, mem_busy
// Out: stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_a, fwd_b
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W          = REG_W_DEF,
    parameter bit FWD_EN         = 1'b1,
    parameter bit RF_BYPASS      = 1'b1,
    parameter int BRANCH_PENALTY = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [REG_W-1:0] id_wn,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    localparam logic [1:0] FLUSH_LD = 2'(BRANCH_PENALTY - 1);

    sb_entry_t  sb_ex;
    sb_entry_t  sb_mem;
    sb_entry_t  sb_wb;
    sb_entry_t  id_ent;
    logic [1:0] fcnt;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       lu_a;
    logic       lu_b;
    logic       st_a;
    logic       st_b;
    logic       hazard;
    logic       flushing;
    logic       active;

    always_comb begin
        id_ent       = '0;
        id_ent.valid = id_valid;
        id_ent.wreg  = id_wreg;
        id_ent.m2reg = id_m2reg;
        id_ent.wn    = REG_W_MAX'(id_wn);
    end

    pipe_fwd_sel #(
        .FWD_EN   (FWD_EN),
        .RF_BYPASS(RF_BYPASS)
    ) u_sel_a (
        .id_valid (id_valid),
        .src      (REG_W_MAX'(id_rs)),
        .use_src  (id_use_rs),
        .ex       (sb_ex),
        .mem      (sb_mem),
        .wb       (sb_wb),
        .sel      (sel_a),
        .load_use (lu_a),
        .stall_req(st_a)
    );

    pipe_fwd_sel #(
        .FWD_EN   (FWD_EN),
        .RF_BYPASS(RF_BYPASS)
    ) u_sel_b (
        .id_valid (id_valid),
        .src      (REG_W_MAX'(id_rt)),
        .use_src  (id_use_rt),
        .ex       (sb_ex),
        .mem      (sb_mem),
        .wb       (sb_wb),
        .sel      (sel_b),
        .load_use (lu_b),
        .stall_req(st_b)
    );

    // Reset gates every output so a mid-stall reset clears at once,
    // even while branch/busy inputs are still asserted.
    assign hazard    = lu_a || lu_b || st_a || st_b;
    assign flushing  = ex_branch_taken || (fcnt != 2'd0);
    assign active    = clrn && !mem_busy;
    assign freeze    = clrn && mem_busy;
    assign flush_id  = active && flushing;
    assign stall_if  = active && !flushing && hazard;
    assign stall_id  = stall_if;
    assign bubble_ex = flush_id || stall_if;
    assign fwd_a     = clrn ? sel_a : FWD_RF;
    assign fwd_b     = clrn ? sel_b : FWD_RF;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
            fcnt   <= 2'd0;
        end else if (!mem_busy) begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= bubble_ex ? '0 : id_ent;
            if (ex_branch_taken)  fcnt <= FLUSH_LD;
            else if (fcnt != 2'd0) fcnt <= fcnt - 2'd1;
        end
    end

endmodule
